// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-stream round-robin arbiter.
package axis_arb_pkg;

  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} arb_state_t;

  localparam int STAT_W = 32;
  localparam int PTR_W  = 5;

  // Wrap-around increment of a requester index; n is the requester count (1..16).
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr,
                                               input logic [PTR_W-1:0] n);
    logic [PTR_W-1:0] nxt;
    if ((ptr + 5'd1) >= n) begin
      nxt = 5'd0;
    end else begin
      nxt = ptr + 5'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: rotate by rr_ptr, priority-encode, rotate back.
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int ID_W   = 2
) (
  input  logic [NUM_IN-1:0] valid,
  input  logic [ID_W-1:0]   rr_ptr,
  output logic [ID_W-1:0]   pick,
  output logic              any_valid
);

  logic [NUM_IN-1:0] rot_s;
  logic [ID_W-1:0]   off_s;
  logic [ID_W:0]     sum_s;

  assign rot_s     = NUM_IN'({valid, valid} >> rr_ptr);
  assign any_valid = |valid;

  // Lowest set bit of the rotated vector is the first requester at or after rr_ptr.
  always_comb begin
    off_s = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? ID_W'(k) : off_s;
    end
  end

  // Undo the rotation modulo NUM_IN.
  always_comb begin
    sum_s = {1'b0, off_s} + {1'b0, rr_ptr};
    if (sum_s >= (ID_W + 1)'(NUM_IN)) begin
      pick = ID_W'(sum_s - (ID_W + 1)'(NUM_IN));
    end else begin
      pick = ID_W'(sum_s);
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// NUM_IN-to-1 AXI-stream round-robin arbiter with bounded bursts and a registered output.
// Define AXIS_ARB_STATS_EN to build the per-input saturating beat counters.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 4,
  parameter int BURST_MAX  = 4,
  parameter int ID_W       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                         s_axis_aclk,
  input  logic                         s_axis_areset,
  input  logic [NUM_IN*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_IN-1:0]            s_axis_tvalid,
  output logic [NUM_IN-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [ID_W-1:0]              m_axis_tid,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  input  logic                         stat_clr,
  output logic [NUM_IN*STAT_W-1:0]     stat_beats
);

  localparam int BC_W = $clog2(BURST_MAX + 1);

  arb_state_t              state_r, state_nxt_s;
  logic [ID_W-1:0]         rr_ptr_r, rr_ptr_nxt_s;
  logic [ID_W-1:0]         gnt_idx_r, gnt_idx_nxt_s;
  logic [BC_W-1:0]         burst_cnt_r, burst_cnt_nxt_s, burst_inc_s;
  logic [DATA_WIDTH-1:0]   m_tdata_r;
  logic [ID_W-1:0]         m_tid_r;
  logic                    m_tvalid_r;
  logic [NUM_IN-1:0]       ready_s;
  logic [ID_W-1:0]         pick_s, sel_idx_s;
  logic                    any_valid_s, load_ok_s, gnt_valid_s, xfer_s;

  axis_rr_pick #(
    .NUM_IN (NUM_IN),
    .ID_W   (ID_W)
  ) u_pick (
    .valid     (s_axis_tvalid),
    .rr_ptr    (rr_ptr_r),
    .pick      (pick_s),
    .any_valid (any_valid_s)
  );

  assign load_ok_s     = ~m_tvalid_r | m_axis_tready;
  assign gnt_valid_s   = |(s_axis_tvalid & (NUM_IN'(1) << gnt_idx_r));
  assign burst_inc_s   = burst_cnt_r + BC_W'(1);
  assign s_axis_tready = s_axis_areset ? '0 : ready_s;
  assign xfer_s        = |(s_axis_tvalid & s_axis_tready);

  // Grant selection and next-state logic.
  always_comb begin
    ready_s         = '0;
    state_nxt_s     = state_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    gnt_idx_nxt_s   = gnt_idx_r;
    burst_cnt_nxt_s = burst_cnt_r;
    sel_idx_s       = gnt_idx_r;
    case (state_r)
      ARB: begin
        sel_idx_s = pick_s;
        if (any_valid_s) begin
          ready_s = NUM_IN'(load_ok_s) << pick_s;
          if (load_ok_s) begin
            gnt_idx_nxt_s   = pick_s;
            rr_ptr_nxt_s    = ID_W'(rr_next(PTR_W'(pick_s), PTR_W'(NUM_IN)));
            burst_cnt_nxt_s = BC_W'(1);
            state_nxt_s     = (BURST_MAX > 1) ? HOLD : ARB;
          end else begin
            state_nxt_s = ARB;
          end
        end else begin
          state_nxt_s = ARB;
        end
      end
      HOLD: begin
        ready_s = NUM_IN'(load_ok_s) << gnt_idx_r;
        if (gnt_valid_s) begin
          if (load_ok_s) begin
            burst_cnt_nxt_s = burst_inc_s;
            state_nxt_s     = (burst_inc_s == BC_W'(BURST_MAX)) ? ARB : HOLD;
          end else begin
            state_nxt_s = HOLD;
          end
        end else begin
          // Granted source went idle: give up the rest of the burst (one bubble).
          state_nxt_s = ARB;
        end
      end
      default: begin
        state_nxt_s = ARB;
      end
    endcase
  end

  // State register and output register slice.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_r     <= ARB;
      rr_ptr_r    <= '0;
      gnt_idx_r   <= '0;
      burst_cnt_r <= '0;
      m_tdata_r   <= '0;
      m_tid_r     <= '0;
      m_tvalid_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      gnt_idx_r   <= gnt_idx_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
      if (xfer_s) begin
        m_tdata_r  <= s_axis_tdata[sel_idx_s*DATA_WIDTH +: DATA_WIDTH];
        m_tid_r    <= sel_idx_s;
        m_tvalid_r <= 1'b1;
      end else if (m_axis_tready) begin
        m_tvalid_r <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = m_tdata_r;
  assign m_axis_tid    = m_tid_r;
  assign m_axis_tvalid = m_tvalid_r;

`ifdef AXIS_ARB_STATS_EN
  logic [STAT_W-1:0] stat_r [NUM_IN];

  // Saturating accepted-beat counters; clear wins over an increment.
  always_ff @(posedge s_axis_aclk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (s_axis_areset || stat_clr) begin
        stat_r[i] <= '0;
      end else if (xfer_s && (sel_idx_s == ID_W'(i)) && (stat_r[i] != 32'hFFFF_FFFF)) begin
        stat_r[i] <= stat_r[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_stat
    assign stat_beats[g*STAT_W +: STAT_W] = stat_r[g];
  end
`else
  logic unused_stat_clr_s;
  assign unused_stat_clr_s = stat_clr;
  assign stat_beats        = '0;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomized bench for axis_rr_arbiter against a grant-ownership reference model.
module tb_axis_rr_arbiter;
  localparam int DW  = 32;
  localparam int N   = 4;
  localparam int BM  = 4;
  localparam int IDW = 2;
`ifdef AXIS_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              s_axis_areset;
  logic [N*DW-1:0]   s_axis_tdata;
  logic [N-1:0]      s_axis_tvalid;
  logic [N-1:0]      s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [IDW-1:0]    m_axis_tid;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              stat_clr;
  logic [N*32-1:0]   stat_beats;

  always #5 clk = ~clk;

  axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_IN(N), .BURST_MAX(BM)) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (s_axis_areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .stat_clr      (stat_clr),
    .stat_beats    (stat_beats)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Source side: each source offers one beat and holds it until accepted.
  bit          src_v [N];
  logic [31:0] src_d [N];
  int          mask    = 15;
  int          p_valid = 100;

  // Reference model: who owns the output, how many burst beats it has left,
  // where the next round-robin search starts, and the expected output register.
  bit          mdl_v;
  logic [31:0] mdl_d;
  int          mdl_id;
  int          holder;
  int          beats_left;
  int          ptr;
  logic [31:0] mdl_stat [N];

  task automatic refresh_src(input int k);
    src_v[k] = (((mask >> k) & 1) == 1) && ($urandom_range(99) < p_valid);
    src_d[k] = $urandom;
  endtask

  task automatic step(input bit tr, input bit clr, input bit rst);
    bit           load_ok;
    int           pick, c, acc;
    logic [N-1:0] exp_rv;
    m_axis_tready = tr;
    stat_clr      = clr;
    s_axis_areset = rst;
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid[i]          = src_v[i];
      s_axis_tdata[i*DW +: DW]  = src_d[i];
    end
    #1;
    load_ok = !mdl_v || tr;
    exp_rv  = '0;
    pick    = -1;
    if (!rst) begin
      if (holder >= 0) begin
        exp_rv[holder] = load_ok;
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (ptr + k) % N;
          if (pick < 0 && src_v[c]) pick = c;
        end
        if (pick >= 0) exp_rv[pick] = load_ok;
      end
    end
    check("s_tready", 32'(s_axis_tready), 32'(exp_rv));
    @(posedge clk);
    acc = -1;
    for (int k = 0; k < N; k++) if (src_v[k] && exp_rv[k]) acc = k;
    if (rst) begin
      mdl_v = 1'b0; mdl_d = '0; mdl_id = 0; holder = -1; beats_left = 0; ptr = 0;
      for (int k = 0; k < N; k++) mdl_stat[k] = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (clr) mdl_stat[k] = '0;
        else if (acc == k && mdl_stat[k] != 32'hFFFF_FFFF) mdl_stat[k] = mdl_stat[k] + 32'd1;
      end
      if (holder >= 0) begin
        if (!src_v[holder]) holder = -1;
        else if (acc == holder) begin
          beats_left--;
          if (beats_left == 0) holder = -1;
        end
      end else if (acc >= 0) begin
        ptr = (acc + 1) % N;
        if (BM > 1) begin
          holder     = acc;
          beats_left = BM - 1;
        end
      end
      if (acc >= 0) begin
        mdl_v = 1'b1; mdl_d = src_d[acc]; mdl_id = acc;
      end else if (tr) begin
        mdl_v = 1'b0;
      end
    end
    for (int k = 0; k < N; k++) if (acc == k || !src_v[k]) refresh_src(k);
    #1;
    check("m_tvalid", 32'(m_axis_tvalid), 32'(mdl_v));
    if (mdl_v || rst) begin
      check("m_tdata", m_axis_tdata, mdl_d);
      check("m_tid", 32'(m_axis_tid), 32'(mdl_id));
    end
    for (int k = 0; k < N; k++)
      check("stat_beats", stat_beats[k*32 +: 32], STATS ? mdl_stat[k] : 32'd0);
  endtask

  task automatic all_valid();
    for (int k = 0; k < N; k++) begin
      src_v[k] = 1'b1;
      src_d[k] = $urandom;
    end
  endtask

  int          nb;
  logic [31:0] hold_d;
  int          hold_id;

  initial begin
    mdl_v = 1'b0; mdl_d = '0; mdl_id = 0; holder = -1; beats_left = 0; ptr = 0;
    for (int k = 0; k < N; k++) begin
      mdl_stat[k] = '0;
      src_v[k]    = 1'b0;
      src_d[k]    = '0;
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);

    // All inputs valid, sink always ready: bursts of BM beats in index order.
    mask = 15; p_valid = 100;
    all_valid();
    nb = 0;
    for (int c = 0; c < 33; c++) begin
      step(1'b1, 1'b0, 1'b0);
      if (m_axis_tvalid) begin
        check("tid_seq", 32'(m_axis_tid), 32'((nb / BM) % N));
        nb++;
      end
    end
    check("tid_seq_cnt", 32'(nb), 32'd33);

    // Sink stall: output held, nothing accepted, then the stream continues.
    hold_d  = mdl_d;
    hold_id = mdl_id;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, 1'b0);
      check("stall_data", m_axis_tdata, hold_d);
      check("stall_tid", 32'(m_axis_tid), 32'(hold_id));
      check("stall_rdy", 32'(s_axis_tready), 32'd0);
    end
    step(1'b1, 1'b0, 1'b0);

    // Reset in the middle of a burst: first grant afterwards goes to input 0.
    step(1'b1, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(m_axis_tvalid), 32'd1);
    step(1'b1, 1'b0, 1'b1);
    check("mid_rst_valid", 32'(m_axis_tvalid), 32'd0);
    all_valid();
    step(1'b1, 1'b0, 1'b0);
    check("post_rst_tid", 32'(m_axis_tid), 32'd0);

    // Ten beats from input 1, then a clear coinciding with another beat.
    step(1'b1, 1'b0, 1'b1);
    mask = 2;
    for (int k = 0; k < N; k++) src_v[k] = 1'b0;
    src_v[1] = 1'b1;
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 1'b0);
    check("stat_pre_clr", stat_beats[63:32], STATS ? 32'd10 : 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("stat_clr", stat_beats[63:32], 32'd0);
    check("clr_beat_tid", 32'(m_axis_tid), 32'd1);

    // Random traffic, sink back-pressure, resets and clears.
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        mask    = ($urandom_range(3) == 0) ? 15 : int'($urandom_range(15));
        p_valid = int'($urandom_range(100, 30));
      end
      step($urandom_range(99) < 70, $urandom_range(99) == 0, $urandom_range(299) == 0);
      check("rdy_onehot", 32'($countones(s_axis_tready) <= 1), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
